writeback_arbiter: RTL and testbench

//  Sole driver of the register file's single write port (write_reg/write_value).

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 79 +++++++
 rtl/writeback_arbiter.sv | 125 ++++++++++++
 tb/tb_writeback_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback path.
package wb_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // One-hot decode of a register index; register 0 never shows as busy.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        v[0] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular result queue for the mult/div unit. Entries can have their
// destination field cleared in place (squash) so a stale result still
// occupies its slot but later pops as a no-op write.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    input  logic                   squash_en,
    input  logic [REG_W-1:0]       squash_rd,
    output wb_entry_t              head,
    output logic [REG_W-1:0]       entry_rd [DEPTH],
    output logic [DEPTH-1:0]       entry_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Expose each slot's destination and whether it currently holds a queued entry.
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_rd[i]    = mem[i].rd;
            entry_valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count);
        end
    end

    // Storage, pointers and occupancy; squash also applies to the entry being pushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_en && (mem[i].rd == squash_rd)) begin
                    mem[i].rd <= '0;
                end
            end
            if (do_push) begin
                mem[wr_ptr].rd   <= (squash_en && (push_entry.rd == squash_rd)) ? '0 : push_entry.rd;
                mem[wr_ptr].data <= push_entry.data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Sole driver of the register file write port. In-order pipeline writes win
// over queued mult/div results; a starvation counter raises stall_pipe so the
// queue can drain. Optional feature macro: WB_BYPASS_EN adds a combinational
// forwarding port for the ID stage.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pipe_wb_en,
    input  logic [REG_W-1:0]       pipe_wb_reg,
    input  logic [DATA_W-1:0]      pipe_wb_value,
    input  logic                   mdu_valid,
    input  logic [REG_W-1:0]       mdu_reg,
    input  logic [DATA_W-1:0]      mdu_value,
    output logic                   mdu_ready,
    output logic [REG_W-1:0]       write_reg,
    output logic [DATA_W-1:0]      write_value,
    output logic                   stall_pipe,
    output logic [NUM_REGS-1:0]    busy_mask,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef WB_BYPASS_EN
    ,
    input  logic [REG_W-1:0]       byp_rs,
    input  logic [REG_W-1:0]       byp_rt,
    output logic [1:0]             byp_hit,
    output logic [DATA_W-1:0]      byp_data
`endif
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic                pipe_win;
    logic                fifo_pop;
    logic                fifo_push;
    logic                fifo_full;
    logic                fifo_empty;
    wb_entry_t           push_entry;
    wb_entry_t           head;
    logic [REG_W-1:0]    entry_rd [DEPTH];
    logic [DEPTH-1:0]    entry_valid;
    logic [STARVE_W-1:0] starve_cnt;

    assign pipe_win   = !stall_pipe && pipe_wb_en && (pipe_wb_reg != '0);
    assign fifo_pop   = !pipe_win && !fifo_empty;
    assign mdu_ready  = !fifo_full;
    assign fifo_push  = mdu_valid && mdu_ready && (mdu_reg != '0);
    assign push_entry = {mdu_reg, mdu_value};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push),
        .push_entry  (push_entry),
        .pop         (fifo_pop),
        .squash_en   (pipe_win),
        .squash_rd   (pipe_wb_reg),
        .head        (head),
        .entry_rd    (entry_rd),
        .entry_valid (entry_valid),
        .count       (fifo_count),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    // Registers that still have a result waiting in the queue.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                busy_mask = busy_mask | reg_onehot(entry_rd[i]);
            end
        end
    end

    // Registered write port: the winner of this cycle commits next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_reg   <= '0;
            write_value <= '0;
        end else if (pipe_win) begin
            write_reg   <= pipe_wb_reg;
            write_value <= pipe_wb_value;
        end else if (fifo_pop) begin
            write_reg   <= head.rd;
            write_value <= head.data;
        end else begin
            write_reg   <= '0;
        end
    end

    // Count cycles the queue head has been waiting; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (fifo_empty || fifo_pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Hold off the pipeline once the head has starved, until the queue empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_pipe <= 1'b0;
        end else if (fifo_empty) begin
            stall_pipe <= 1'b0;
        end else if (starve_cnt >= STARVE_W'(STARVE_LIMIT)) begin
            stall_pipe <= 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    assign byp_hit[0] = (byp_rs == write_reg) && (write_reg != '0);
    assign byp_hit[1] = (byp_rt == write_reg) && (write_reg != '0);
    assign byp_data   = write_value;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_writeback_arbiter;
    import wb_pkg::*;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wb_en;
    logic [4:0]  pipe_wb_reg;
    logic [31:0] pipe_wb_value;
    logic        mdu_valid;
    logic [4:0]  mdu_reg;
    logic [31:0] mdu_value;
    logic        mdu_ready;
    logic [4:0]  write_reg;
    logic [31:0] write_value;
    logic        stall_pipe;
    logic [31:0] busy_mask;
    logic [2:0]  fifo_count;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_rs = '0;
    logic [4:0]  byp_rt = '0;
    logic [1:0]  byp_hit;
    logic [31:0] byp_data;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    wb_entry_t   mq[$];
    logic [4:0]  m_wreg;
    logic [31:0] m_wval;
    int          m_starve;
    logic        m_stall;
    logic [31:0] rf [32];

    writeback_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_wb_en    (pipe_wb_en),
        .pipe_wb_reg   (pipe_wb_reg),
        .pipe_wb_value (pipe_wb_value),
        .mdu_valid     (mdu_valid),
        .mdu_reg       (mdu_reg),
        .mdu_value     (mdu_value),
        .mdu_ready     (mdu_ready),
        .write_reg     (write_reg),
        .write_value   (write_value),
        .stall_pipe    (stall_pipe),
        .busy_mask     (busy_mask),
        .fifo_count    (fifo_count)
`ifdef WB_BYPASS_EN
        ,
        .byp_rs        (byp_rs),
        .byp_rt        (byp_rt),
        .byp_hit       (byp_hit),
        .byp_data      (byp_data)
`endif
    );

    always #5 clk = ~clk;

    // Upstream must never present a write while stalled
    always @(posedge clk) begin
        if (!rst && stall_pipe && pipe_wb_en)
            $error("[TB] contract violation: pipe_wb_en high while stall_pipe high");
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        foreach (mq[i]) if (mq[i].rd != 0) b[mq[i].rd] = 1'b1;
        return b;
    endfunction

    // Apply the writeback rules to the model for the inputs present at this edge
    task automatic model_step();
        int        sz;
        bit        win, pop, push;
        wb_entry_t e;
        if (rst) begin
            mq.delete();
            m_wreg = '0; m_wval = '0; m_starve = 0; m_stall = 1'b0;
            return;
        end
        sz   = mq.size();
        win  = !m_stall && pipe_wb_en && (pipe_wb_reg != 0);
        pop  = !win && (sz > 0);
        push = mdu_valid && (sz < DEPTH) && (mdu_reg != 0);
        if (sz == 0) m_stall = 1'b0;
        else if (m_starve >= STARVE_LIMIT) m_stall = 1'b1;
        if (sz == 0 || pop) m_starve = 0;
        else m_starve = m_starve + 1;
        if (win) begin
            m_wreg = pipe_wb_reg; m_wval = pipe_wb_value;
        end else if (pop) begin
            e = mq.pop_front();
            m_wreg = e.rd; m_wval = e.data;
        end else begin
            m_wreg = '0;
        end
        if (win) foreach (mq[i]) if (mq[i].rd == pipe_wb_reg) mq[i].rd = '0;
        if (push) begin
            e.rd   = (win && mdu_reg == pipe_wb_reg) ? 5'd0 : mdu_reg;
            e.data = mdu_value;
            mq.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (write_reg != 0) rf[write_reg] = write_value;
    endtask

    task automatic idle();
        pipe_wb_en = 0; pipe_wb_reg = 0; pipe_wb_value = 0;
        mdu_valid = 0; mdu_reg = 0; mdu_value = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        pipe_wb_en = 1; pipe_wb_reg = 2; pipe_wb_value = 32'h2;
        mdu_valid = 1; mdu_reg = 6; mdu_value = 32'h6;
        tick();
        mdu_reg = 8; mdu_value = 32'h8;
        tick();
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("[TB] FAIL pre_reset_count: got %0d expected 2", fifo_count); end
        rst = 1; tick(); rst = 0; idle();
        checks++; if (write_reg !== 5'd0) begin errors++; $display("[TB] FAIL reset_write_reg: got %0d expected 0", write_reg); end
        checks++; if (write_value !== 32'd0) begin errors++; $display("[TB] FAIL reset_write_value: got %0h expected 0", write_value); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
        checks++; if (stall_pipe !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %0b expected 0", stall_pipe); end
        checks++; if (busy_mask !== 32'd0) begin errors++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy_mask); end
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b expected 1", mdu_ready); end
    endtask

    task automatic test_pipe_write();
        do_reset();
        pipe_wb_en = 1; pipe_wb_reg = 5; pipe_wb_value = 32'hDEADBEEF;
        tick(); idle();
        checks++; if (write_reg !== 5'd5) begin errors++; $display("[TB] FAIL pipe_reg: got %0d expected 5", write_reg); end
        checks++; if (write_value !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL pipe_value: got %0h expected deadbeef", write_value); end
        tick();
        checks++; if (write_reg !== 5'd0) begin errors++; $display("[TB] FAIL pipe_idle_reg: got %0d expected 0", write_reg); end
    endtask

    task automatic test_priority();
        do_reset();
        pipe_wb_en = 1; pipe_wb_reg = 3; pipe_wb_value = 32'h33;
        mdu_valid = 1; mdu_reg = 7; mdu_value = 32'h11;
        for (int c = 0; c < 3; c++) begin
            tick();
            mdu_valid = 0;
            checks++; if (busy_mask[7] !== 1'b1) begin errors++; $display("[TB] FAIL prio_busy7 c%0d: got %0b expected 1", c, busy_mask[7]); end
            checks++; if (write_reg !== 5'd3) begin errors++; $display("[TB] FAIL prio_pipe c%0d: got %0d expected 3", c, write_reg); end
        end
        idle(); tick();
        checks++; if (write_reg !== 5'd7) begin errors++; $display("[TB] FAIL prio_mdu_reg: got %0d expected 7", write_reg); end
        checks++; if (write_value !== 32'h11) begin errors++; $display("[TB] FAIL prio_mdu_value: got %0h expected 11", write_value); end
        checks++; if (busy_mask !== 32'd0) begin errors++; $display("[TB] FAIL prio_busy_clear: got %0h expected 0", busy_mask); end
    endtask

    task automatic test_full();
        logic [4:0] got[$];
        bit accepted = 0;
        do_reset();
        pipe_wb_en = 1; pipe_wb_reg = 1; pipe_wb_value = 32'h1;
        for (int i = 0; i < 4; i++) begin
            mdu_valid = 1; mdu_reg = 5'(10 + i); mdu_value = 32'h100 + i;
            tick();
        end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL full_count: got %0d expected 4", fifo_count); end
        checks++; if (mdu_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %0b expected 0", mdu_ready); end
        mdu_reg = 14; mdu_value = 32'h114;
        tick();
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL full_hold_count: got %0d expected 4", fifo_count); end
        pipe_wb_en = 0;
        for (int k = 0; k < 10 && !accepted; k++) begin
            if (mdu_ready === 1'b1) accepted = 1;
            tick();
            if (write_reg != 0) got.push_back(write_reg);
        end
        mdu_valid = 0;
        checks++; if (!accepted) begin errors++; $display("[TB] FAIL full_accept: got no slot expected slot within 10 cycles"); end
        for (int k = 0; k < 8; k++) begin
            tick();
            if (write_reg != 0) got.push_back(write_reg);
        end
        checks++; if (got.size() != 5) begin errors++; $display("[TB] FAIL full_drain_len: got %0d expected 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            checks++; if (got[i] !== 5'(10 + i)) begin errors++; $display("[TB] FAIL full_drain_order[%0d]: got %0d expected %0d", i, got[i], 10 + i); end
        end
    endtask

    task automatic test_squash();
        do_reset();
        pipe_wb_en = 1; pipe_wb_reg = 2; pipe_wb_value = 32'h22;
        mdu_valid = 1; mdu_reg = 9; mdu_value = 32'hAA;
        tick();
        mdu_valid = 0; pipe_wb_reg = 9; pipe_wb_value = 32'hBB;
        tick(); idle();
        checks++; if (write_reg !== 5'd9 || write_value !== 32'hBB) begin errors++; $display("[TB] FAIL squash_pipe: got %0d/%0h expected 9/bb", write_reg, write_value); end
        checks++; if (busy_mask[9] !== 1'b0) begin errors++; $display("[TB] FAIL squash_busy: got %0b expected 0", busy_mask[9]); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL squash_slot_kept: got %0d expected 1", fifo_count); end
        tick();
        checks++; if (write_reg !== 5'd0) begin errors++; $display("[TB] FAIL squash_noop_pop: got %0d expected 0", write_reg); end
        checks++; if (rf[9] !== 32'hBB) begin errors++; $display("[TB] FAIL squash_final_r9: got %0h expected bb", rf[9]); end
        pipe_wb_en = 1; pipe_wb_reg = 12; pipe_wb_value = 32'hCC;
        mdu_valid = 1; mdu_reg = 12; mdu_value = 32'hDD;
        tick(); idle();
        checks++; if (busy_mask !== 32'd0 || fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL squash_same_cycle: got busy %0h count %0d expected 0/1", busy_mask, fifo_count); end
        tick();
        checks++; if (write_reg !== 5'd0) begin errors++; $display("[TB] FAIL squash_same_pop: got %0d expected 0", write_reg); end
    endtask

    task automatic test_starvation();
        int n = 0;
        do_reset();
        pipe_wb_en = 1; pipe_wb_reg = 4; pipe_wb_value = 32'h44;
        mdu_valid = 1; mdu_reg = 20; mdu_value = 32'h2020;
        tick();
        mdu_valid = 0;
        while (!stall_pipe && n < 30) begin
            tick(); n++;
        end
        pipe_wb_en = 0;
        checks++; if (n != STARVE_LIMIT + 1) begin errors++; $display("[TB] FAIL starve_latency: got %0d expected %0d", n, STARVE_LIMIT + 1); end
        tick();
        checks++; if (write_reg !== 5'd20 || write_value !== 32'h2020) begin errors++; $display("[TB] FAIL starve_drain: got %0d/%0h expected 20/2020", write_reg, write_value); end
        checks++; if (stall_pipe !== 1'b1 || fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL starve_empty: got stall %0b count %0d expected 1/0", stall_pipe, fifo_count); end
        tick();
        checks++; if (stall_pipe !== 1'b0) begin errors++; $display("[TB] FAIL starve_release: got %0b expected 0", stall_pipe); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            pipe_wb_en    = ($urandom_range(0, 3) != 0) && !stall_pipe;
            pipe_wb_reg   = 5'($urandom_range(0, 7));
            pipe_wb_value = $urandom;
            mdu_valid     = 1'($urandom_range(0, 1));
            mdu_reg       = 5'($urandom_range(0, 7));
            mdu_value     = $urandom;
            tick();
`ifdef WB_BYPASS_EN
            byp_rs = 5'($urandom_range(0, 7));
            byp_rt = 5'($urandom_range(0, 7));
            #1;
            checks++; if (byp_hit !== {(byp_rt == m_wreg) && m_wreg != 0, (byp_rs == m_wreg) && m_wreg != 0}) begin errors++; $display("[TB] FAIL rnd_byp_hit c%0d: got %0b", c, byp_hit); end
`endif
            checks++; if (write_reg !== m_wreg) begin errors++; $display("[TB] FAIL rnd_write_reg c%0d: got %0d expected %0d", c, write_reg, m_wreg); end
            checks++; if (m_wreg != 0 && write_value !== m_wval) begin errors++; $display("[TB] FAIL rnd_write_value c%0d: got %0h expected %0h", c, write_value, m_wval); end
            checks++; if (fifo_count !== 3'(mq.size())) begin errors++; $display("[TB] FAIL rnd_count c%0d: got %0d expected %0d", c, fifo_count, mq.size()); end
            checks++; if (stall_pipe !== m_stall) begin errors++; $display("[TB] FAIL rnd_stall c%0d: got %0b expected %0b", c, stall_pipe, m_stall); end
            checks++; if (busy_mask !== m_busy()) begin errors++; $display("[TB] FAIL rnd_busy c%0d: got %0h expected %0h", c, busy_mask, m_busy()); end
            checks++; if (mdu_ready !== (mq.size() < DEPTH)) begin errors++; $display("[TB] FAIL rnd_ready c%0d: got %0b expected %0b", c, mdu_ready, mq.size() < DEPTH); end
        end
        idle();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = '0;
        idle();
        rst = 1;
        $display("[TB] starting writeback_arbiter tests");
        test_reset();
        test_pipe_write();
        test_priority();
        test_full();
        test_squash();
        test_starvation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
